// File: rtl/pin_keypad_frontend_pkg.sv
// pin_keypad_frontend_pkg
// Shared types and helpers for the keypad front end: FSM state encoding,
// digit and button widths, and the one-hot/population-count helpers used
// by the press encoder.
package pin_keypad_frontend_pkg;

  localparam int DIGIT_W   = 2;
  localparam int BTN_COUNT = 4;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_EMIT         = 2'd1,
    ST_WAIT_RELEASE = 2'd2
  } fe_state_t;

  // One-hot button vector to binary digit value; only called with a
  // single bit set, anything else maps to 0.
  function automatic logic [DIGIT_W-1:0] onehot_to_bin(input logic [BTN_COUNT-1:0] oh);
    logic [DIGIT_W-1:0] bin;
    case (oh)
      4'b0001: bin = 2'd0;
      4'b0010: bin = 2'd1;
      4'b0100: bin = 2'd2;
      4'b1000: bin = 2'd3;
      default: bin = 2'd0;
    endcase
    return bin;
  endfunction

  // Number of buttons set in a vector.
  function automatic logic [2:0] btn_count(input logic [BTN_COUNT-1:0] v);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < BTN_COUNT; i++) begin
      n = n + {2'b00, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/pin_keypad_frontend_if.sv
// pin_keypad_frontend_if
// Link between the keypad front end and the PIN checker.
//   checker_ready : checker idle (checker -> front end)
//   digit         : last accepted digit value
//   submit        : one-cycle strobe, digit valid in the same cycle
//   entry_count   : digits accepted in the current entry
//   entry_done    : pulse with the submit of the final digit of a PIN
//   timeout_abort : pulse when a partial entry times out
//   chord_err     : pulse when several buttons were pressed together
// master = front end, slave = checker.
interface pin_keypad_frontend_if;
  import pin_keypad_frontend_pkg::*;

  logic               checker_ready;
  logic [DIGIT_W-1:0] digit;
  logic               submit;
  logic [2:0]         entry_count;
  logic               entry_done;
  logic               timeout_abort;
  logic               chord_err;

  modport master (
    input  checker_ready,
    output digit, submit, entry_count, entry_done, timeout_abort, chord_err
  );

  modport slave (
    output checker_ready,
    input  digit, submit, entry_count, entry_done, timeout_abort, chord_err
  );
endinterface

// File: rtl/pin_button_debounce.sv
// pin_button_debounce
// Two-flop synchroniser followed by a persistence counter for one raw
// button. The stable output flips only after the synchronised value has
// disagreed with it for DEBOUNCE_CYCLES consecutive clocks.
//   clk    : system clock
//   reset  : asynchronous active-low reset
//   raw    : asynchronous button input
//   stable : debounced, registered button state
module pin_button_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic stable
);

  localparam int             DW       = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [DW-1:0]  CNT_FLIP = DW'(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0]  CNT_ONE  = DW'(32'd1);

  logic          sync1_r;
  logic          sync2_r;
  logic [DW-1:0] cnt_r;
  logic          stable_r;

  // Synchroniser, mismatch counter and stable state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_r  <= 1'b0;
      sync2_r  <= 1'b0;
      cnt_r    <= {DW{1'b0}};
      stable_r <= 1'b0;
    end else begin
      sync1_r <= raw;
      sync2_r <= sync1_r;
      if (sync2_r == stable_r) begin
        cnt_r <= {DW{1'b0}};
      end else if (cnt_r == CNT_FLIP) begin
        // Counter already holds DEBOUNCE_CYCLES earlier mismatches; this is
        // the cycle the mismatch has lasted long enough.
        stable_r <= sync2_r;
        cnt_r    <= {DW{1'b0}};
      end else begin
        cnt_r <= cnt_r + CNT_ONE;
      end
    end
  end

  assign stable = stable_r;

endmodule

// File: rtl/pin_keypad_frontend.sv
// pin_keypad_frontend
// Conditions four digit buttons and turns each clean single press into a
// digit plus submit strobe for the PIN checker. Rejects chords, counts
// digits within an entry and aborts a partial entry on inactivity.
//   clk     : system clock
//   reset   : asynchronous active-low reset
//   btn_raw : raw buttons, bit k pressed = digit value k
//   bus     : checker link (master side), see pin_keypad_frontend_if
module pin_keypad_frontend
  import pin_keypad_frontend_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TIMEOUT_CYCLES  = 1024,
  parameter int PIN_DIGITS      = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BTN_COUNT-1:0] btn_raw,
  pin_keypad_frontend_if.master bus
);

  localparam int            TW       = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TMR_ONE  = TW'(32'd1);
  localparam logic [2:0]    CNT_LAST = 3'(PIN_DIGITS - 1);

  logic [BTN_COUNT-1:0] stable_s;
  logic [BTN_COUNT-1:0] stable_prev_r;
  logic [BTN_COUNT-1:0] rise_s;
  logic                 press_s;
  logic                 multi_s;
  logic                 accept_s;
  logic                 tmo_hit_s;

  fe_state_t            state_r;
  logic [DIGIT_W-1:0]   digit_r;
  logic                 submit_r;
  logic [2:0]           entry_count_r;
  logic                 entry_done_r;
  logic                 timeout_abort_r;
  logic                 chord_err_r;
  logic [TW-1:0]        tmr_r;

  for (genvar k = 0; k < BTN_COUNT; k++) begin : g_btn
    pin_button_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk    (clk),
      .reset  (reset),
      .raw    (btn_raw[k]),
      .stable (stable_s[k])
    );
  end

  // Previous debounced state, used to spot rising edges.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stable_prev_r <= {BTN_COUNT{1'b0}};
    end else begin
      stable_prev_r <= stable_s;
    end
  end

  // Press detection, chord detection, accept and timeout-expiry decode.
  always_comb begin
    rise_s    = stable_s & ~stable_prev_r;
    press_s   = (state_r == ST_IDLE) && (rise_s != {BTN_COUNT{1'b0}});
    multi_s   = (btn_count(stable_s) >= 3'd2);
    accept_s  = press_s && !multi_s && bus.checker_ready;
    tmo_hit_s = (entry_count_r != 3'd0) && (tmr_r == TMO_LAST);
  end

  // Inter-digit timer: idle at 0 with no partial entry, restarts on each
  // accepted digit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmr_r <= {TW{1'b0}};
    end else if (accept_s || (entry_count_r == 3'd0) || tmo_hit_s) begin
      tmr_r <= {TW{1'b0}};
    end else begin
      tmr_r <= tmr_r + TMR_ONE;
    end
  end

  // Entry FSM with registered strobes. The submit/digit/count update is
  // registered on the transition into EMIT so the strobe is high exactly
  // while the FSM sits in EMIT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r         <= ST_IDLE;
      digit_r         <= {DIGIT_W{1'b0}};
      submit_r        <= 1'b0;
      entry_count_r   <= 3'd0;
      entry_done_r    <= 1'b0;
      timeout_abort_r <= 1'b0;
      chord_err_r     <= 1'b0;
    end else begin
      submit_r        <= 1'b0;
      entry_done_r    <= 1'b0;
      timeout_abort_r <= 1'b0;
      chord_err_r     <= 1'b0;

      // An accept in the expiry cycle restarts the entry instead.
      if (tmo_hit_s && !accept_s) begin
        timeout_abort_r <= 1'b1;
        entry_count_r   <= 3'd0;
      end

      case (state_r)
        ST_IDLE: begin
          if (press_s) begin
            if (multi_s) begin
              chord_err_r <= 1'b1;
              state_r     <= ST_WAIT_RELEASE;
            end else if (bus.checker_ready) begin
              digit_r  <= onehot_to_bin(stable_s);
              submit_r <= 1'b1;
              if (entry_count_r == CNT_LAST) begin
                entry_done_r  <= 1'b1;
                entry_count_r <= 3'd0;
              end else begin
                entry_count_r <= entry_count_r + 3'd1;
              end
              state_r <= ST_EMIT;
            end else begin
              state_r <= ST_WAIT_RELEASE;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_EMIT: begin
          state_r <= ST_WAIT_RELEASE;
        end
        ST_WAIT_RELEASE: begin
          if (stable_s == {BTN_COUNT{1'b0}}) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_WAIT_RELEASE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.digit         = digit_r;
  assign bus.submit        = submit_r;
  assign bus.entry_count   = entry_count_r;
  assign bus.entry_done    = entry_done_r;
  assign bus.timeout_abort = timeout_abort_r;
  assign bus.chord_err     = chord_err_r;

endmodule

// File: tb/tb_pin_keypad_frontend.sv
// tb_pin_keypad_frontend
// Directed stimulus with a cycle-level behavioural model of the keypad
// front end, compared against the DUT every clock, plus literal checks on
// latencies, digit values and pulse counts.
module tb_pin_keypad_frontend;
  import pin_keypad_frontend_pkg::*;

  localparam int DEB = 16;
  localparam int TMO = 64;
  localparam int PIN = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] btn_raw = 4'b0000;

  pin_keypad_frontend_if bus();

  pin_keypad_frontend #(
    .DEBOUNCE_CYCLES (DEB),
    .TIMEOUT_CYCLES  (TMO),
    .PIN_DIGITS      (PIN)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (btn_raw),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model state: raw history (index j = value sampled j edges ago),
  // debounced value after the previous two edges, entry bookkeeping.
  logic [3:0] hist [0:DEB+2];
  logic [3:0] m_st1 = 4'b0000;
  logic [3:0] m_st2 = 4'b0000;
  bit         m_busy = 1'b0;
  logic [2:0] m_cnt = 3'd0;
  logic [1:0] m_digit = 2'd0;
  bit         m_submit = 1'b0, m_done = 1'b0, m_abort = 1'b0, m_chord = 1'b0;
  int         m_last_sub = 0;

  // Observations of the DUT for the literal checks.
  int sub_cnt = 0, last_sub_cyc = 0, last_sub_digit = 0, last_sub_count = 0;
  int done_cnt = 0, done_cyc = 0, ab_cnt = 0, ab_cyc = 0, ch_cnt = 0;
  int sub_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, cyc, act, exp);
    end
  endtask

  // Advance the model by one rising edge.
  task automatic model_step();
    logic [3:0] nst;
    logic [3:0] rise;
    bit         accept;
    bit         all_diff;
    m_submit = 1'b0;
    m_done   = 1'b0;
    m_abort  = 1'b0;
    m_chord  = 1'b0;
    if (!reset) begin
      for (int j = 0; j <= DEB + 2; j++) hist[j] = 4'b0000;
      m_st1 = 4'b0000;
      m_st2 = 4'b0000;
      m_busy = 1'b0;
      m_cnt = 3'd0;
      m_digit = 2'd0;
    end else begin
      for (int j = DEB + 2; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = btn_raw;
      // A button flips once its raw value, seen two edges late, has
      // differed from the debounced value on DEB+1 consecutive edges.
      nst = m_st1;
      for (int k = 0; k < 4; k++) begin
        all_diff = 1'b1;
        for (int j = 2; j <= DEB + 2; j++) begin
          if (hist[j][k] == m_st1[k]) all_diff = 1'b0;
        end
        if (all_diff) nst[k] = ~m_st1[k];
      end
      rise = m_st1 & ~m_st2;
      accept = 1'b0;
      if (!m_busy) begin
        if (rise != 4'b0000) begin
          m_busy = 1'b1;
          if ($countones(m_st1) >= 2) begin
            m_chord = 1'b1;
          end else if (bus.checker_ready) begin
            accept = 1'b1;
            m_submit = 1'b1;
            for (int k = 0; k < 4; k++) if (m_st1[k]) m_digit = 2'(k);
            if (int'(m_cnt) == PIN - 1) begin
              m_done = 1'b1;
              m_cnt = 3'd0;
            end else begin
              m_cnt = m_cnt + 3'd1;
            end
            m_last_sub = cyc;
          end
        end
      end else if (m_st1 == 4'b0000) begin
        m_busy = 1'b0;
      end
      if (!accept && m_cnt != 3'd0 && (cyc - m_last_sub) == TMO) begin
        m_abort = 1'b1;
        m_cnt = 3'd0;
      end
      m_st2 = m_st1;
      m_st1 = nst;
    end
  endtask

  // Compare process: step the model at each rising edge, check 1 ns later.
  initial begin
    for (int j = 0; j <= DEB + 2; j++) hist[j] = 4'b0000;
    forever begin
      @(posedge clk);
      cyc++;
      model_step();
      #1;
      chk("submit", bus.submit, m_submit);
      chk("digit", bus.digit, m_digit);
      chk("entry_count", bus.entry_count, m_cnt);
      chk("entry_done", bus.entry_done, m_done);
      chk("timeout_abort", bus.timeout_abort, m_abort);
      chk("chord_err", bus.chord_err, m_chord);
      if (bus.submit === 1'b1) begin
        sub_cnt++;
        last_sub_cyc = cyc;
        last_sub_digit = int'(bus.digit);
        last_sub_count = int'(bus.entry_count);
        sub_q.push_back(int'(bus.digit));
      end
      if (bus.entry_done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (bus.timeout_abort === 1'b1) begin
        ab_cnt++;
        ab_cyc = cyc;
      end
      if (bus.chord_err === 1'b1) ch_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Hold v for 'hold' clocks, then release for 'rel' clocks; t_edge is the
  // first rising edge that samples the new raw value.
  task automatic press(input logic [3:0] v, input int hold, input int rel, output int t_edge);
    @(negedge clk);
    btn_raw = v;
    t_edge = cyc + 1;
    tick(hold);
    btn_raw = 4'b0000;
    tick(rel);
  endtask

  initial begin
    int t, s0, d0, a0, c0, n;
    bus.checker_ready = 1'b1;
    tick(3);
    chk("reset_submit", bus.submit, 0);
    chk("reset_count", bus.entry_count, 0);
    @(negedge clk);
    reset = 1'b1;
    tick(3);

    // Single press of digit 2, then let the partial entry time out.
    s0 = sub_cnt;
    a0 = ab_cnt;
    press(4'b0100, 40, 25, t);
    chk("single_nsub", sub_cnt - s0, 1);
    chk("single_latency", last_sub_cyc - t, 19);
    chk("single_digit", last_sub_digit, 2);
    chk("single_count", last_sub_count, 1);
    tick(45);
    chk("timeout_n", ab_cnt - a0, 1);
    chk("timeout_delay", ab_cyc - last_sub_cyc, 64);
    chk("timeout_count", bus.entry_count, 0);

    // Bouncing button 1: toggles every 3 clocks, then a clean hold.
    s0 = sub_cnt;
    for (int i = 0; i < 10; i++) begin
      btn_raw = (i % 2 == 0) ? 4'b0010 : 4'b0000;
      tick(3);
    end
    chk("bounce_nsub_during", sub_cnt - s0, 0);
    press(4'b0010, 25, 25, t);
    chk("bounce_nsub", sub_cnt - s0, 1);
    chk("bounce_latency", last_sub_cyc - t, 19);
    chk("bounce_digit", last_sub_digit, 1);
    tick(70);

    // Full PIN 2,2,1,1.
    s0 = sub_cnt;
    d0 = done_cnt;
    press(4'b0100, 22, 20, t);
    press(4'b0100, 22, 20, t);
    press(4'b0010, 22, 20, t);
    press(4'b0010, 22, 20, t);
    n = sub_q.size();
    chk("pin_nsub", sub_cnt - s0, 4);
    chk("pin_d0", sub_q[n-4], 2);
    chk("pin_d1", sub_q[n-3], 2);
    chk("pin_d2", sub_q[n-2], 1);
    chk("pin_d3", sub_q[n-1], 1);
    chk("pin_ndone", done_cnt - d0, 1);
    chk("pin_done_coincident", done_cyc - last_sub_cyc, 0);
    chk("pin_count_end", bus.entry_count, 0);

    // Chord 0+1, then a clean press of 3.
    s0 = sub_cnt;
    c0 = ch_cnt;
    press(4'b0011, 25, 25, t);
    chk("chord_n", ch_cnt - c0, 1);
    chk("chord_nsub", sub_cnt - s0, 0);
    chk("chord_count", bus.entry_count, 0);
    press(4'b1000, 25, 25, t);
    chk("after_chord_digit", last_sub_digit, 3);
    chk("after_chord_nsub", sub_cnt - s0, 1);
    tick(70);

    // Checker busy: press is dropped.
    s0 = sub_cnt;
    bus.checker_ready = 1'b0;
    press(4'b0001, 25, 25, t);
    chk("notready_nsub", sub_cnt - s0, 0);
    chk("notready_digit", bus.digit, 3);
    bus.checker_ready = 1'b1;

    // Reset mid-debounce with the button still held afterwards.
    @(negedge clk);
    btn_raw = 4'b0001;
    tick(10);
    reset = 1'b0;
    tick(2);
    chk("midreset_digit", bus.digit, 0);
    chk("midreset_submit", bus.submit, 0);
    s0 = sub_cnt;
    reset = 1'b1;
    t = cyc + 1;
    tick(30);
    chk("postreset_nsub", sub_cnt - s0, 1);
    chk("postreset_latency", last_sub_cyc - t, 19);
    chk("postreset_digit", last_sub_digit, 0);
    btn_raw = 4'b0000;
    tick(30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
